// File: rtl/frame_streamer_pkg.sv
// -----------------------------------------------------------------------------
// frame_streamer_pkg
// Shared definitions for the frame pixel streamer:
//   - FSM state encodings (ST_IDLE..ST_DONE, 3 bits, legacy-compatible
//     localparams rather than an enum so the encodings can be mirrored in
//     the cnn_accel register map).
//   - Default field widths, shared with the cnn_accel map definitions.
//   - A helper that derives the frame address width from the size width.
// -----------------------------------------------------------------------------
package frame_streamer_pkg;

  // Default widths.
  localparam int W_SIZE_DEF  = 12;  // width/height field (max 4095)
  localparam int W_DELAY_DEF = 12;  // start-up / hsync delay counters
  localparam int W_PIX_DEF   = 32;  // 4 x 8-bit channels

  // FSM state encodings.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STARTUP = 3'd1;
  localparam logic [2:0] ST_LINE    = 3'd2;
  localparam logic [2:0] ST_HBLANK  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // width*height of two W_SIZE fields always fits in 2*W_SIZE bits; the
  // extra bit keeps the address map identical to the writer side.
  function automatic int frame_addr_width(input int w_size);
    return 2 * w_size + 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Column / row / delay counters of the frame pixel streamer, with the
// terminal-count flags the controlling FSM branches on.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr_i         clear all counters (frame start / frame end)
//   col_en_i      advance column; wraps to 0 after width_i-1 and bumps row
//   dly_en_i      advance delay counter; wraps to 0 after dly_tgt_i-1
//   width_i       pixels per line (shadowed config)
//   height_i      lines per frame (shadowed config)
//   dly_tgt_i     length of the delay currently being counted (non-zero)
//   col_first_o   column counter is 0
//   col_last_o    column counter is width_i-1
//   row_last_o    row counter is height_i-1
//   dly_last_o    delay counter is dly_tgt_i-1 (last idle cycle)
// -----------------------------------------------------------------------------
module raster_counter
  import frame_streamer_pkg::*;
#(
  parameter int W_SIZE  = W_SIZE_DEF,
  parameter int W_DELAY = W_DELAY_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               col_en_i,
  input  logic               dly_en_i,
  input  logic [W_SIZE-1:0]  width_i,
  input  logic [W_SIZE-1:0]  height_i,
  input  logic [W_DELAY-1:0] dly_tgt_i,
  output logic               col_first_o,
  output logic               col_last_o,
  output logic               row_last_o,
  output logic               dly_last_o
);

  logic [W_SIZE-1:0]  col_q, col_d;
  logic [W_SIZE-1:0]  row_q, row_d;
  logic [W_DELAY-1:0] dly_q, dly_d;

  assign col_first_o = (col_q == '0);
  assign col_last_o  = (col_q == width_i  - W_SIZE'(1));
  assign row_last_o  = (row_q == height_i - W_SIZE'(1));
  assign dly_last_o  = (dly_q == dly_tgt_i - W_DELAY'(1));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    col_d = col_q;
    row_d = row_q;
    dly_d = dly_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
      dly_d = '0;
    end else begin
      if (col_en_i) begin
        if (col_last_o) begin
          col_d = '0;
          // Row can reach height after the last line; it is cleared before
          // the next frame and never compared in that state.
          row_d = row_q + W_SIZE'(1);
        end else begin
          col_d = col_q + W_SIZE'(1);
        end
      end
      if (dly_en_i) begin
        dly_d = dly_last_o ? '0 : dly_q + W_DELAY'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      dly_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops
      // update together from values sampled before the edge.
      col_q <= col_d;
      row_q <= row_d;
      dly_q <= dly_d;
    end
  end

endmodule

// File: rtl/frame_pixel_streamer.sv
// -----------------------------------------------------------------------------
// frame_pixel_streamer
// Replays a stored image from a single-port sync-read frame memory as a
// raster pixel stream with a start-up delay before the first line and an
// hsync delay between lines (cnn_accel input timing).
//
// Build option:
//   FRAME_STREAMER_CONTINUOUS_EN  when defined, the frame repeats with the
//                                 same shadow config until an i_start pulse
//                                 while busy requests a stop after the
//                                 current frame. Undefined: single shot.
//
// Ports:
//   HCLK, HRESETn       clock (rising edge), asynchronous active-low reset
//   i_start             single-cycle frame start request (ignored while busy)
//   i_width, i_height   frame geometry, latched at start
//   i_start_up_delay    idle cycles before the first line, latched at start
//   i_hsync_delay       idle cycles between lines, latched at start
//   o_mem_rd_en         frame memory read enable
//   o_mem_addr          linear pixel address row*width+col
//   i_mem_rdata         read data, valid one cycle after o_mem_rd_en
//   o_pixel, o_valid    output pixel and its qualifier
//   o_line_start        o_valid of column 0
//   o_busy              high from accepted start through the frame_done cycle
//   o_frame_done        one-cycle pulse after the last o_valid
// -----------------------------------------------------------------------------
module frame_pixel_streamer
  import frame_streamer_pkg::*;
#(
  parameter int W_SIZE       = W_SIZE_DEF,
  parameter int W_DELAY      = W_DELAY_DEF,
  parameter int W_FRAME_SIZE = 2 * W_SIZE + 1,
  parameter int W_PIX        = W_PIX_DEF
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    i_start,
  input  logic [W_SIZE-1:0]       i_width,
  input  logic [W_SIZE-1:0]       i_height,
  input  logic [W_DELAY-1:0]      i_start_up_delay,
  input  logic [W_DELAY-1:0]      i_hsync_delay,
  output logic                    o_mem_rd_en,
  output logic [W_FRAME_SIZE-1:0] o_mem_addr,
  input  logic [W_PIX-1:0]        i_mem_rdata,
  output logic [W_PIX-1:0]        o_pixel,
  output logic                    o_valid,
  output logic                    o_line_start,
  output logic                    o_busy,
  output logic                    o_frame_done
);

  // FSM and shadow configuration.
  logic [2:0]              state_q, state_d;
  logic [W_SIZE-1:0]       width_q, width_d;
  logic [W_SIZE-1:0]       height_q, height_d;
  logic [W_DELAY-1:0]      sud_q, sud_d;
  logic [W_DELAY-1:0]      hsd_q, hsd_d;
  logic [W_FRAME_SIZE-1:0] addr_q, addr_d;
  logic                    done_q, done_d;

  // Output pipeline.
  logic                    valid_q;
  logic                    col0_q;

  // Counter interface.
  logic                    cnt_clr;
  logic                    col_en;
  logic                    dly_en;
  logic [W_DELAY-1:0]      dly_tgt;
  logic                    col_first;
  logic                    col_last;
  logic                    row_last;
  logic                    dly_last;

  logic                    rd_en;
  logic                    start_ok;

  assign rd_en = (state_q == ST_LINE);

  // The IDLE cycle that carries o_frame_done still counts as busy, so a
  // start request there is dropped.
  assign start_ok = i_start && !done_q;

  // One delay counter serves both STARTUP and HBLANK.
  assign dly_tgt = (state_q == ST_STARTUP) ? sud_q : hsd_q;

`ifdef FRAME_STREAMER_CONTINUOUS_EN
  logic stop_q;
  logic stop_req;

  // A start pulse while busy requests a stop; one arriving in DONE itself
  // still stops the loop before the next frame begins.
  assign stop_req = stop_q || i_start;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stop_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      stop_q <= 1'b0;
    end else if (i_start) begin
      stop_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    sud_d    = sud_q;
    hsd_d    = hsd_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    col_en   = 1'b0;
    dly_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          width_d  = i_width;
          height_d = i_height;
          sud_d    = i_start_up_delay;
          hsd_d    = i_hsync_delay;
          addr_d   = '0;
          cnt_clr  = 1'b1;
          if (i_width == '0 || i_height == '0) begin
            state_d = ST_DONE;
          end else if (i_start_up_delay == '0) begin
            state_d = ST_LINE;
          end else begin
            state_d = ST_STARTUP;
          end
        end
      end

      ST_STARTUP: begin
        dly_en = 1'b1;
        if (dly_last) begin
          state_d = ST_LINE;
        end
      end

      ST_LINE: begin
        col_en = 1'b1;
        // Address runs continuously across lines: row*width+col.
        addr_d = addr_q + W_FRAME_SIZE'(1);
        if (col_last) begin
          if (row_last) begin
            state_d = ST_DONE;
          end else if (hsd_q == '0) begin
            state_d = ST_LINE;
          end else begin
            state_d = ST_HBLANK;
          end
        end
      end

      ST_HBLANK: begin
        dly_en = 1'b1;
        if (dly_last) begin
          state_d = ST_LINE;
        end
      end

      ST_DONE: begin
        // The last read issued in LINE returns during this cycle, so its
        // o_valid is showing now and o_frame_done lands one cycle later.
        done_d  = 1'b1;
        addr_d  = '0;
        cnt_clr = 1'b1;
`ifdef FRAME_STREAMER_CONTINUOUS_EN
        if (stop_req || width_q == '0 || height_q == '0) begin
          state_d = ST_IDLE;
        end else if (sud_q == '0) begin
          state_d = ST_LINE;
        end else begin
          state_d = ST_STARTUP;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      width_q  <= '0;
      height_q <= '0;
      sud_q    <= '0;
      hsd_q    <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      col0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      sud_q    <= sud_d;
      hsd_q    <= hsd_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      valid_q  <= rd_en;
      col0_q   <= rd_en && col_first;
    end
  end

  raster_counter #(
    .W_SIZE  (W_SIZE),
    .W_DELAY (W_DELAY)
  ) u_raster_counter (
    .clk         (HCLK),
    .rst_n       (HRESETn),
    .clr_i       (cnt_clr),
    .col_en_i    (col_en),
    .dly_en_i    (dly_en),
    .width_i     (width_q),
    .height_i    (height_q),
    .dly_tgt_i   (dly_tgt),
    .col_first_o (col_first),
    .col_last_o  (col_last),
    .row_last_o  (row_last),
    .dly_last_o  (dly_last)
  );

  assign o_mem_rd_en  = rd_en;
  assign o_mem_addr   = addr_q;
  // The sync-read memory's output register is the data stage; gating with
  // valid_q keeps o_pixel at 0 outside valid cycles and during reset.
  assign o_pixel      = valid_q ? i_mem_rdata : '0;
  assign o_valid      = valid_q;
  assign o_line_start = valid_q && col0_q;
  assign o_busy       = (state_q != ST_IDLE) || done_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// -----------------------------------------------------------------------------
// tb_frame_pixel_streamer
// Self-checking bench for frame_pixel_streamer (default single-shot build).
// The reference model computes, for every cycle after a start request, the
// expected read strobe/address and output timing directly from the frame
// geometry and delays; a sync-read memory model supplies pixel data.
// -----------------------------------------------------------------------------
module tb_frame_pixel_streamer;

  localparam int W_SIZE       = 12;
  localparam int W_DELAY      = 12;
  localparam int W_FRAME_SIZE = 25;
  localparam int W_PIX        = 32;
  localparam int MEM_DEPTH    = 16384;

  logic                    HCLK = 1'b0;
  logic                    HRESETn = 1'b0;
  logic                    i_start = 1'b0;
  logic [W_SIZE-1:0]       i_width = '0;
  logic [W_SIZE-1:0]       i_height = '0;
  logic [W_DELAY-1:0]      i_start_up_delay = '0;
  logic [W_DELAY-1:0]      i_hsync_delay = '0;
  logic                    o_mem_rd_en;
  logic [W_FRAME_SIZE-1:0] o_mem_addr;
  logic [W_PIX-1:0]        i_mem_rdata = '0;
  logic [W_PIX-1:0]        o_pixel;
  logic                    o_valid;
  logic                    o_line_start;
  logic                    o_busy;
  logic                    o_frame_done;

  int checks   = 0;
  int failures = 0;

  logic [W_PIX-1:0] mem [MEM_DEPTH];

  frame_pixel_streamer dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .i_start          (i_start),
    .i_width          (i_width),
    .i_height         (i_height),
    .i_start_up_delay (i_start_up_delay),
    .i_hsync_delay    (i_hsync_delay),
    .o_mem_rd_en      (o_mem_rd_en),
    .o_mem_addr       (o_mem_addr),
    .i_mem_rdata      (i_mem_rdata),
    .o_pixel          (o_pixel),
    .o_valid          (o_valid),
    .o_line_start     (o_line_start),
    .o_busy           (o_busy),
    .o_frame_done     (o_frame_done)
  );

  always #5 HCLK = ~HCLK;

  // Single-port sync-read frame memory.
  always @(posedge HCLK) begin
    if (o_mem_rd_en) begin
      if (int'(o_mem_addr) < MEM_DEPTH) i_mem_rdata <= mem[int'(o_mem_addr)];
      else                              i_mem_rdata <= 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: read k cycles after the start cycle. Reads start after the
  // start cycle plus the start-up delay, each line is w reads followed by
  // hsd idle cycles, h lines in total.
  function automatic void model_rd(input int k, input int w, input int h,
                                   input int sud, input int hsd,
                                   output bit en, output int addr, output bit first);
    int t, p, r, c;
    en = 1'b0; addr = 0; first = 1'b0;
    if (w == 0 || h == 0) return;
    t = k - 1 - sud;
    if (t < 0) return;
    p = w + hsd;
    r = t / p;
    c = t % p;
    if (r < h && c < w) begin
      en    = 1'b1;
      addr  = r * w + c;
      first = (c == 0);
    end
  endfunction

  function automatic int done_cycle(input int w, input int h, input int sud, input int hsd);
    if (w == 0 || h == 0) return 2;
    return sud + w * h + (h - 1) * hsd + 2;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, o_mem_rd_en,  0);
    check({tag, "_addr"},  o_mem_addr,   0);
    check({tag, "_valid"}, o_valid,      0);
    check({tag, "_pixel"}, o_pixel,      0);
    check({tag, "_lstart"}, o_line_start, 0);
    check({tag, "_busy"},  o_busy,       0);
    check({tag, "_done"},  o_frame_done, 0);
  endtask

  // Reset in the middle of a frame, then check nothing resumes.
  task automatic do_abort();
    #2;
    HRESETn = 1'b0;
    i_start = 1'b0;
    #1;
    check_all_zero("abort_async");
    repeat (3) @(negedge HCLK);
    check_all_zero("abort_hold");
    HRESETn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      check("abort_no_done", o_frame_done, 0);
      check("abort_idle_busy", o_busy, 0);
    end
  endtask

  // Issues one start, then compares every output each cycle against the
  // model until a few cycles past frame_done. With noise, extra starts and
  // changing config inputs are driven while busy; they must have no effect.
  task automatic run_frame(input int w, input int h, input int sud, input int hsd,
                           input bit noise, input int abort_k);
    int  d;
    bit  en, first, en_prev, first_prev;
    int  addr, addr_prev;
    d = done_cycle(w, h, sud, hsd);
    @(negedge HCLK);
    i_start          = 1'b1;
    i_width          = W_SIZE'(w);
    i_height         = W_SIZE'(h);
    i_start_up_delay = W_DELAY'(sud);
    i_hsync_delay    = W_DELAY'(hsd);
    en_prev = 1'b0; first_prev = 1'b0; addr_prev = 0;
    for (int k = 1; k <= d + 3; k++) begin
      @(negedge HCLK);
      model_rd(k, w, h, sud, hsd, en, addr, first);
      check("rd_en", o_mem_rd_en, en);
      if (en) check("addr", o_mem_addr, addr);
      check("valid", o_valid, en_prev);
      if (en_prev) check("pixel", o_pixel, mem[addr_prev]);
      check("line_start", o_line_start, en_prev & first_prev);
      check("frame_done", o_frame_done, k == d);
      check("busy", o_busy, k <= d);
      en_prev = en; first_prev = first; addr_prev = addr;
      i_start = 1'b0;
      if (noise && k <= d) begin
        i_start          = ($urandom_range(0, 7) == 0) || (k == sud + 3) || (k == d);
        i_width          = (k == sud + 3) ? W_SIZE'(w + 5) : W_SIZE'($urandom);
        i_height         = W_SIZE'($urandom);
        i_start_up_delay = W_DELAY'($urandom);
        i_hsync_delay    = W_DELAY'($urandom);
      end
      if (abort_k > 0 && k == abort_k) begin
        do_abort();
        return;
      end
    end
    i_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;

    #2;
    check_all_zero("reset");
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    check_all_zero("post_reset");

    run_frame(4, 2, 3, 2, 1'b0, -1);      // basic frame
    run_frame(3, 3, 0, 0, 1'b0, -1);      // zero delays
    run_frame(0, 5, 4, 1, 1'b0, -1);      // degenerate width
    run_frame(5, 0, 0, 0, 1'b0, -1);      // degenerate height
    run_frame(6, 3, 2, 1, 1'b1, -1);      // start while busy + config churn
    run_frame(1, 1, 0, 0, 1'b0, -1);      // single pixel

    for (int n = 0; n < 10; n++) begin
      run_frame($urandom_range(0, 10), $urandom_range(0, 6),
                $urandom_range(0, 5), $urandom_range(0, 4),
                1'(($urandom_range(0, 1))), -1);
    end

    // Abort during line 2 of a 128x128 frame, then a fresh frame from addr 0.
    run_frame(128, 128, 5, 3, 1'b0, 1 + 5 + 131 + 40);
    run_frame(4, 3, 1, 1, 1'b0, -1);

    run_frame(128, 128, 200, 160, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
